keycode_cmd: RTL and testbench

KEYCODE_CMD -- requirements
Module: keycode_cmd

---
 rtl/game_pkg.sv | 22 ++
 rtl/vs_edge_sync.sv | 23 ++
 rtl/keycode_cmd.sv | 76 +++++++
 tb/tb_keycode_cmd.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared heading/fire-state types and HID keycode constants.
package game_pkg;

    typedef enum logic [1:0] {UP = 2'd0, LEFT = 2'd1, DOWN = 2'd2, RIGHT = 2'd3} dir_t;
    typedef enum logic {IDLE = 1'b0, COOLDOWN = 1'b1} fire_state_t;

    localparam logic [7:0] KC_W     = 8'h1A;
    localparam logic [7:0] KC_A     = 8'h04;
    localparam logic [7:0] KC_S     = 8'h16;
    localparam logic [7:0] KC_D     = 8'h07;
    localparam logic [7:0] KC_SPACE = 8'h2C;
    localparam logic [7:0] KC_P     = 8'h13;

    function automatic logic is_dir(input logic [7:0] kc);
        return (kc == KC_W) || (kc == KC_A) || (kc == KC_S) || (kc == KC_D);
    endfunction

    function automatic dir_t kc_dir(input logic [7:0] kc);
        return (kc == KC_A) ? LEFT : (kc == KC_S) ? DOWN : (kc == KC_D) ? RIGHT : UP;
    endfunction

endpackage

// File: rtl/vs_edge_sync.sv
// vs_edge_sync: 2-flop synchronizer on vsync plus a registered one-cycle falling-edge pulse.
module vs_edge_sync (
    input  logic Clk,
    input  logic Reset_n,
    input  logic vs,
    output logic tick
);

    // sync[0..1] form the synchronizer, sync[2] is the previous synchronized level;
    // all reset to 1 so no edge can appear from reset values alone.
    logic [2:0] sync;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync <= 3'b111;
            tick <= 1'b0;
        end else begin
            sync <= {sync[1:0], vs};
            tick <= sync[2] & ~sync[1];
        end
    end

endmodule

// File: rtl/keycode_cmd.sv
// keycode_cmd: turns frame-sampled HID keycodes into ship heading, rate-limited fire and pause.
module keycode_cmd
    import game_pkg::*;
#(
    parameter int unsigned STABLE_FRAMES   = 2,
    parameter int unsigned COOLDOWN_FRAMES = 8
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [7:0] keycode,
    input  logic       frame_vs,
    output logic       frame_tick,
    output dir_t       dir,
    output logic       fire,
    output logic       paused
);

    localparam logic [3:0] STAB    = 4'(STABLE_FRAMES);
    localparam logic [5:0] CD_LOAD = 6'(COOLDOWN_FRAMES - 1);

    logic [7:0]  kc_q;
    logic [7:0]  cap;
    logic [3:0]  stab_cnt;
    logic [3:0]  stab_nxt;
    logic [5:0]  cnt;
    fire_state_t state;

    vs_edge_sync u_sync (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .vs      (frame_vs),
        .tick    (frame_tick)
    );

    always_comb
        stab_nxt = (kc_q != cap) ? 4'd1 : (stab_cnt == 4'd15) ? 4'd15 : stab_cnt + 4'd1;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            kc_q     <= 8'h00;
            cap      <= 8'h00;
            stab_cnt <= 4'd0;
            dir      <= UP;
            fire     <= 1'b0;
            paused   <= 1'b0;
            state    <= IDLE;
            cnt      <= 6'd0;
        end else begin
            kc_q <= keycode;
            fire <= 1'b0;
            if (frame_tick) begin
                cap      <= kc_q;
                stab_cnt <= stab_nxt;
                if (kc_q == KC_P && cap != KC_P)
                    paused <= ~paused;
                // Pause freezes heading and the fire FSM; stability tracking keeps running.
                if (!paused) begin
                    if (stab_nxt >= STAB && is_dir(kc_q))
                        dir <= kc_dir(kc_q);
                    if (state == IDLE) begin
                        if (kc_q == KC_SPACE) begin
                            fire  <= 1'b1;
                            state <= COOLDOWN;
                            cnt   <= CD_LOAD;
                        end
                    end else if (cnt == 6'd0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 6'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_keycode_cmd.sv
// tb_keycode_cmd: directed checks of keycode_cmd with default parameters.
module tb_keycode_cmd;
    import game_pkg::*;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic [7:0] keycode;
    logic       frame_vs;
    logic       frame_tick;
    dir_t       dir;
    logic       fire;
    logic       paused;

    int n_run = 0;
    int n_fail = 0;
    int tick_num = 0;
    int fire_cyc = 0;
    int fire_ticks[$];

    keycode_cmd dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .keycode    (keycode),
        .frame_vs   (frame_vs),
        .frame_tick (frame_tick),
        .dir        (dir),
        .fire       (fire),
        .paused     (paused)
    );

    initial forever #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (frame_tick) tick_num++;
        if (fire) begin
            fire_cyc++;
            fire_ticks.push_back(tick_num);
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic frame();
        frame_vs = 1'b0;
        cyc(6);
        frame_vs = 1'b1;
        cyc(4);
    endtask

    task automatic frames(input int n);
        repeat (n) frame();
    endtask

    function automatic int fire_at(input int idx, input int base);
        return (fire_ticks.size() > idx) ? fire_ticks[idx] - base : -1;
    endfunction

    task automatic toggle_frame();
        keycode = KC_W;  cyc(1000);
        keycode = KC_S;  cyc(1000);
        keycode = KC_W;  cyc(1000);
        keycode = KC_S;  cyc(10);
        frame();
    endtask

    initial begin
        int fc0, fc1, bi, bt;
        Reset_n = 1'b0;
        frame_vs = 1'b1;
        keycode = 8'h00;
        cyc(3);
        check("rst_tick", int'(frame_tick), 0);
        check("rst_dir", int'(dir), int'(UP));
        check("rst_fire", int'(fire), 0);
        check("rst_paused", int'(paused), 0);
        Reset_n = 1'b1;
        cyc(5);
        check("no_tick_after_rst", tick_num, 0);

        frame_vs = 1'b0;
        cyc(2);
        check("tick_early", int'(frame_tick), 0);
        cyc(1);
        check("tick_at_3", int'(frame_tick), 1);
        cyc(1);
        check("tick_one_wide", int'(frame_tick), 0);
        frame_vs = 1'b1;
        cyc(4);
        check("tick_count", tick_num, 1);

        keycode = KC_D;
        frame();
        check("dir_unstable", int'(dir), int'(UP));
        frame_vs = 1'b0;
        cyc(3);
        check("dir_in_tick", int'(dir), int'(UP));
        cyc(1);
        check("dir_right", int'(dir), int'(RIGHT));
        frame_vs = 1'b1;
        cyc(5);
        frame();
        keycode = 8'h00;
        frames(2);
        check("dir_hold_none", int'(dir), int'(RIGHT));

        bi = fire_ticks.size();
        bt = tick_num;
        fc0 = fire_cyc;
        keycode = KC_SPACE;
        frames(20);
        check("fire_count", fire_ticks.size() - bi, 3);
        check("fire_width", fire_cyc - fc0, 3);
        check("fire_t1", fire_at(bi, bt), 1);
        check("fire_t10", fire_at(bi + 1, bt), 10);
        check("fire_t19", fire_at(bi + 2, bt), 19);
        check("dir_hold_fire", int'(dir), int'(RIGHT));
        keycode = 8'h00;
        frames(10);

        keycode = KC_P;
        frame();
        check("pause_on", int'(paused), 1);
        frames(3);
        check("pause_held", int'(paused), 1);
        keycode = 8'h00;
        frame();
        check("pause_release", int'(paused), 1);
        keycode = KC_P;
        frame();
        check("pause_off", int'(paused), 0);

        keycode = 8'h00;
        frame();
        keycode = KC_P;
        frame();
        check("pause_again", int'(paused), 1);
        fc0 = fire_cyc;
        keycode = KC_SPACE;
        frames(5);
        keycode = KC_A;
        frames(5);
        check("paused_no_fire", fire_cyc - fc0, 0);
        check("paused_dir", int'(dir), int'(RIGHT));
        keycode = KC_P;
        frame();
        check("unpause", int'(paused), 0);
        keycode = KC_SPACE;
        bt = tick_num;
        frame();
        check("unpause_fire", fire_cyc - fc0, 1);
        check("unpause_fire_tick", fire_at(fire_ticks.size() - 1, bt), 1);

        keycode = 8'h00;
        frames(3);
        frame_vs = 1'b0;
        cyc(1);
        #2 Reset_n = 1'b0;
        #1;
        check("async_dir", int'(dir), int'(UP));
        check("async_fire", int'(fire), 0);
        check("async_paused", int'(paused), 0);
        check("async_tick", int'(frame_tick), 0);
        cyc(3);
        frame_vs = 1'b1;
        keycode = KC_SPACE;
        cyc(3);
        Reset_n = 1'b1;
        fc1 = fire_cyc;
        bt = tick_num;
        cyc(5);
        check("no_residual_fire", fire_cyc - fc1, 0);
        frame();
        check("fire_after_rst", fire_cyc - fc1, 1);
        check("fire_after_rst_tick", fire_at(fire_ticks.size() - 1, bt), 1);

        toggle_frame();
        check("toggle_tick1", int'(dir), int'(UP));
        toggle_frame();
        check("toggle_down", int'(dir), int'(DOWN));

        keycode = 8'h55;
        frames(2);
        check("dir_hold_unknown", int'(dir), int'(DOWN));
        keycode = KC_A;
        frames(2);
        check("dir_left", int'(dir), int'(LEFT));
        keycode = KC_W;
        frame();
        check("dir_w_unstable", int'(dir), int'(LEFT));
        frame();
        check("dir_up", int'(dir), int'(UP));

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
